// File: rtl/uart_pkg.sv
// Shared UART framer types: FSM state encoding and line-level bit constants.
// PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } uart_state_e;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and flags the
// last cycle of each bit period with expire.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = enable && (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmit framer: accepts a byte over valid/ready and serialises it.
// Define UART_TX_PARITY_EN to add an even-parity bit between data and stop.
module uart_tx_framer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_serial,
    output logic                 tx_busy,
    output logic                 frame_done
);

`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = DATA_BITS + 3;
`else
    localparam int FRAME_BITS = DATA_BITS + 2;
`endif
    localparam int BCW = 3;
    localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_BITS - 1);

    uart_state_e           state_q, state_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic [BCW-1:0]        bit_q, bit_d;
    logic [FRAME_BITS-1:0] frame_w;
    logic                  tmr_clear;
    logic                  tmr_expire;

`ifdef UART_TX_PARITY_EN
    assign frame_w = {STOP_BIT, ^tx_data, tx_data, START_BIT};
`else
    assign frame_w = {STOP_BIT, tx_data, START_BIT};
`endif

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (tmr_clear),
        .enable(tx_busy),
        .expire(tmr_expire)
    );

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_d      = bit_q;
        tx_ready   = 1'b0;
        tx_busy    = 1'b1;
        frame_done = 1'b0;
        tmr_clear  = 1'b0;
        unique case (state_q)
            IDLE: begin
                tx_ready = 1'b1;
                tx_busy  = 1'b0;
                if (tx_valid) begin
                    state_d   = START;
                    shift_d   = frame_w;
                    bit_d     = '0;
                    tmr_clear = 1'b1;
                end
            end
            START: begin
                if (tmr_expire) begin
                    state_d = DATA;
                    shift_d = {1'b1, shift_q[FRAME_BITS-1:1]};
                end
            end
            DATA: begin
                if (tmr_expire) begin
                    shift_d = {1'b1, shift_q[FRAME_BITS-1:1]};
                    if (bit_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tmr_expire) begin
                    state_d = STOP;
                    shift_d = {1'b1, shift_q[FRAME_BITS-1:1]};
                end
            end
`endif
            STOP: begin
                if (tmr_expire) begin
                    frame_done = 1'b1;
                    state_d    = IDLE;
                    shift_d    = {1'b1, shift_q[FRAME_BITS-1:1]};
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '1;
            bit_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
        end
    end

    // Idle line is forced high so a stale shift value can never leak out.
    assign tx_serial = (state_q == IDLE) ? STOP_BIT : shift_q[0];

endmodule

// File: tb/tb_uart_tx_framer.sv
// Self-checking bench for uart_tx_framer with a per-cycle expected-line queue.
module tb_uart_tx_framer;

    localparam int CPB = 10;
    localparam int DB  = 8;
`ifdef UART_TX_PARITY_EN
    localparam int FB = DB + 3;
`else
    localparam int FB = DB + 2;
`endif
    localparam int FLEN = FB * CPB;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DB-1:0] tx_data = '0;
    logic          tx_valid = 1'b0;
    logic          tx_ready;
    logic          tx_serial;
    logic          tx_busy;
    logic          frame_done;

    int n_checks = 0;
    int n_fail   = 0;

    logic exp_ser[$];
    logic exp_done[$];

    always #5 clk = ~clk;

    uart_tx_framer #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS   (DB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_serial (tx_serial),
        .tx_busy   (tx_busy),
        .frame_done(frame_done)
    );

    function automatic void push_frame(input logic [DB-1:0] d);
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < DB; i++) bits.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
        bits.push_back(^d);
`endif
        bits.push_back(1'b1);
        foreach (bits[b]) begin
            for (int c = 0; c < CPB; c++) begin
                exp_ser.push_back(bits[b]);
                exp_done.push_back((b == FB - 1) && (c == CPB - 1));
            end
        end
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (tx_serial !== 1'b1 || tx_ready !== 1'b1 ||
            tx_busy !== 1'b0 || frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: serial=%b ready=%b busy=%b done=%b req 1 1 0 0",
                     tx_serial, tx_ready, tx_busy, frame_done);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_frame(input logic [DB-1:0] d);
        logic es, ed;
        int done_at;
        done_at = -1;
        @(negedge clk);
        n_checks++;
        if (tx_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL frame_ready %h: ready=%b req 1", d, tx_ready);
        end
        tx_data = d;
        tx_valid = 1'b1;
        @(posedge clk);
        #1 tx_valid = 1'b0;
        push_frame(d);
        for (int k = 1; k <= FLEN; k++) begin
            @(negedge clk);
            es = exp_ser.pop_front();
            ed = exp_done.pop_front();
            if (frame_done === 1'b1) done_at = k;
            n_checks++;
            if (tx_serial !== es || frame_done !== ed || tx_busy !== 1'b1) begin
                n_fail++;
                $display("FAIL frame %h cyc %0d: serial=%b done=%b busy=%b req %b %b 1",
                         d, k, tx_serial, frame_done, tx_busy, es, ed);
            end
        end
        n_checks++;
        if (done_at != FLEN) begin
            n_fail++;
            $display("FAIL frame_done_cycle %h: got %0d req %0d", d, done_at, FLEN);
        end
        @(negedge clk);
        n_checks++;
        if (tx_serial !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL frame_idle %h: serial=%b ready=%b busy=%b req 1 1 0",
                     d, tx_serial, tx_ready, tx_busy);
        end
    endtask

    task automatic test_back_to_back();
        logic es, ed, er;
        @(negedge clk);
        tx_data = 8'h00;
        tx_valid = 1'b1;
        @(posedge clk);
        #1 tx_data = 8'hFF;
        push_frame(8'h00);
        exp_ser.push_back(1'b1);
        exp_done.push_back(1'b0);
        push_frame(8'hFF);
        for (int i = 0; i < 2 * FLEN + 1; i++) begin
            @(negedge clk);
            es = exp_ser.pop_front();
            ed = exp_done.pop_front();
            er = (i == FLEN);
            n_checks++;
            if (tx_serial !== es || frame_done !== ed || tx_ready !== er) begin
                n_fail++;
                $display("FAIL b2b cyc %0d: serial=%b done=%b ready=%b req %b %b %b",
                         i, tx_serial, frame_done, tx_ready, es, ed, er);
            end
            if (i == FLEN) begin
                @(posedge clk);
                #1 tx_valid = 1'b0;
            end
        end
        repeat (2 * CPB) begin
            @(negedge clk);
            n_checks++;
            if (tx_serial !== 1'b1 || tx_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_after: serial=%b busy=%b req 1 0", tx_serial, tx_busy);
            end
        end
    endtask

    task automatic test_ignore_midframe();
        logic es, ed;
        @(negedge clk);
        tx_data = 8'h5A;
        tx_valid = 1'b1;
        @(posedge clk);
        #1 tx_valid = 1'b0;
        push_frame(8'h5A);
        for (int k = 1; k <= FLEN; k++) begin
            @(negedge clk);
            if (k == 33) begin
                tx_data = 8'h3C;
                tx_valid = 1'b1;
            end else begin
                tx_valid = 1'b0;
            end
            es = exp_ser.pop_front();
            ed = exp_done.pop_front();
            n_checks++;
            if (tx_serial !== es || frame_done !== ed) begin
                n_fail++;
                $display("FAIL ignore cyc %0d: serial=%b done=%b req %b %b",
                         k, tx_serial, frame_done, es, ed);
            end
        end
        repeat (2 * CPB) begin
            @(negedge clk);
            n_checks++;
            if (tx_serial !== 1'b1 || tx_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL ignore_second: serial=%b busy=%b req 1 0", tx_serial, tx_busy);
            end
        end
    endtask

    task automatic test_reset_midframe();
        logic es, ed;
        @(negedge clk);
        tx_data = 8'hA5;
        tx_valid = 1'b1;
        @(posedge clk);
        #1 tx_valid = 1'b0;
        push_frame(8'hA5);
        // Data bit 3 spans cycles 41..50 after acceptance.
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            es = exp_ser.pop_front();
            ed = exp_done.pop_front();
            n_checks++;
            if (tx_serial !== es || frame_done !== ed) begin
                n_fail++;
                $display("FAIL rstmid_pre cyc %0d: serial=%b done=%b req %b %b",
                         k, tx_serial, frame_done, es, ed);
            end
        end
        exp_ser.delete();
        exp_done.delete();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (tx_serial !== 1'b1 || tx_ready !== 1'b1 ||
            tx_busy !== 1'b0 || frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid: serial=%b ready=%b busy=%b done=%b req 1 1 0 0",
                     tx_serial, tx_ready, tx_busy, frame_done);
        end
        repeat (FLEN) begin
            @(negedge clk);
            n_checks++;
            if (tx_serial !== 1'b1 || frame_done !== 1'b0) begin
                n_fail++;
                $display("FAIL rstmid_after: serial=%b done=%b req 1 0", tx_serial, frame_done);
            end
        end
    endtask

    task automatic test_rst_priority();
        @(negedge clk);
        rst = 1'b1;
        tx_data = 8'h00;
        tx_valid = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tx_valid = 1'b0;
        repeat (2 * CPB) begin
            n_checks++;
            if (tx_serial !== 1'b1 || tx_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_prio: serial=%b busy=%b req 1 0", tx_serial, tx_busy);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_frame(8'hA5);
        test_frame(8'h07);
        test_frame(8'h80);
        test_back_to_back();
        test_ignore_midframe();
        test_reset_midframe();
        test_rst_priority();
        test_frame(8'h3C);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_framer.md
UART_TX_FRAMER -- requirements
Module: uart_tx_framer

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 10, meaning clock cycles per serial bit period (legal range 2..1023).
REQ-002 SHALL have parameter DATA_BITS, default 8, meaning payload bits per frame (legal range 5..8).
REQ-003 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port tx_data  input  DATA_BITS  byte to transmit, sampled only on acceptance.
REQ-006 SHALL have port tx_valid  input  1  producer has a byte on tx_data.
REQ-007 SHALL have port tx_ready  output  1  framer can accept a byte this cycle.
REQ-008 SHALL have port tx_serial  output  1  serial line, idle high.
REQ-009 SHALL have port tx_busy  output  1  a frame is in progress.
REQ-010 SHALL have port frame_done  output  1  single-cycle pulse at the end of each frame.

Function
REQ-011 SHALL accept a byte in exactly the cycles where tx_valid and tx_ready are both high; tx_valid with tx_ready low is ignored and nothing is latched.
REQ-012 SHALL assert tx_ready only in state IDLE.
REQ-013 SHALL use FSM states IDLE, START, DATA, PARITY (macro builds only), and STOP.
REQ-014 SHALL transition IDLE->START on acceptance, START->DATA, DATA->PARITY or STOP after DATA_BITS bits, PARITY->STOP, and STOP->IDLE; every non-IDLE state advances only when the bit timer expires.
REQ-015 SHALL capture the frame {stop=1, [parity], data, start=0} into an internal parallel-to-serial register on acceptance and shift it LSB-first, filling with 1.
REQ-016 SHALL drive tx_serial low in the cycle after acceptance (1-cycle latency).
REQ-017 SHALL hold each bit on tx_serial for exactly CLKS_PER_BIT cycles; the bit timer counts 0..CLKS_PER_BIT-1, wraps to 0, and restarts at 0 on acceptance.
REQ-018 SHALL transmit data bits LSB first.
REQ-019 SHALL pulse frame_done for one cycle during the last cycle of the stop bit.
REQ-020 SHALL re-enter IDLE the cycle after frame_done, so back-to-back frames have exactly one idle-high cycle between them (frame period (FRAME_BITS*CLKS_PER_BIT)+1 cycles).
REQ-021 SHALL assert tx_busy in every state except IDLE.
REQ-022 SHALL drive tx_serial high in IDLE regardless of tx_data.

Reset
REQ-023 SHALL, on rst high at a clock edge, enter IDLE, set tx_serial=1, tx_ready=1, tx_busy=0, frame_done=0, clear the bit timer, and set the shift register to all ones.
REQ-024 SHALL abandon a frame when reset asserts mid-frame, with no frame_done and tx_serial high from the following cycle.
REQ-025 SHALL give rst priority over a simultaneous tx_valid; that byte is not accepted.

Configuration
REQ-026 SHALL, with macro UART_TX_PARITY_EN defined, insert one even-parity bit (XOR of data bits) between data and stop, so FRAME_BITS = DATA_BITS+3.
REQ-027 SHALL, without UART_TX_PARITY_EN, omit the PARITY state and bit, so FRAME_BITS = DATA_BITS+2.

Structure
REQ-028 SHALL take the state enum type and the START_BIT=0 and STOP_BIT=1 constants from shared package uart_pkg.
REQ-029 SHALL implement the bit-period counter as sub-module uart_bit_timer, with ports clk, rst, clear, enable, and expire.

Verification
REQ-030 SHALL check: reset, then 0xA5 accepted with CLKS_PER_BIT=10 and no parity -> tx_serial = 0,1,0,1,0,0,1,0,1,1, each held 10 cycles; frame_done at cycle 100 after acceptance.
REQ-031 SHALL check: UART_TX_PARITY_EN, 0x07 -> parity bit 1 before stop; 11 bits total; frame_done at cycle 110.
REQ-032 SHALL check: tx_valid held high for 2 frames (0x00, 0xFF) -> exactly 1 idle-high cycle between frames; tx_ready high only in that cycle.
REQ-033 SHALL check: tx_valid pulsed with 0x3C mid-frame -> ignored; the current frame is unchanged; no second frame.
REQ-034 SHALL check: rst asserted during data bit 3 -> next cycle tx_serial=1, tx_ready=1, tx_busy=0; no frame_done pulse.
REQ-035 SHALL check: rst and tx_valid high in the same cycle -> no acceptance; line stays idle.
